// File: rtl/tc_negate_pipe_if.sv
// Stream bundle for tc_negate_pipe: input beat, output beat, mode controls and overflow flag.
// The slave modport is the negate stage itself; master is whatever drives it.
interface tc_negate_pipe_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic                      dv;
  logic                      drdy;
  logic [1:0]                mode;
  logic                      phclr;
  logic [CHANNELS*WIDTH-1:0] y;
  logic                      yv;
  logic                      yrdy;
  logic                      ovf;
  logic                      ovfclr;

  modport master (
    output din, dv, mode, phclr, yrdy, ovfclr,
    input  drdy, y, yv, ovf
  );

  modport slave (
    input  din, dv, mode, phclr, yrdy, ovfclr,
    output drdy, y, yv, ovf
  );
endinterface

// File: rtl/tc_negate_pipe.sv
// Two-stage true/complement stage for multi-channel sample streams with valid/ready,
// optional saturation, fs/2 alternate-sign mode and odd-channel (conjugate) negate.
module tc_negate_pipe #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter bit SAT      = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  tc_negate_pipe_if.slave bus
);

  localparam int CW = CHANNELS * WIDTH;

  logic                     vld_p1;
  logic                     vld_p2;
  logic [CHANNELS-1:0]      neg_p1;
  logic signed [WIDTH-1:0]  dat_p1 [CHANNELS];
  logic [CW-1:0]            y_p2;
  logic                     ovf_q;
  logic                     phase;

  logic                     adv1;
  logic                     adv2;
  logic                     accept;
  logic                     phase_use;
  logic [CHANNELS-1:0]      neg_d;
  logic signed [WIDTH:0]    sum_p2 [CHANNELS];
  logic [CHANNELS-1:0]      ovf_ch;
  logic [CW-1:0]            y_d;

  // Two's-complement negate is ~D + 1; the +1 is deferred to S2 and done with a guard bit.
  function automatic logic signed [WIDTH:0] add_guard(input logic signed [WIDTH-1:0] d,
                                                      input logic n);
    return {d[WIDTH-1], d} + {{WIDTH{1'b0}}, n};
  endfunction

  function automatic logic sat_wrap_ovf(input logic signed [WIDTH:0] s);
    return s[WIDTH] ^ s[WIDTH-1];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_wrap(input logic signed [WIDTH:0] s);
    if (SAT && sat_wrap_ovf(s))
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      return s[WIDTH-1:0];
  endfunction

  assign adv2     = !vld_p2 || bus.yrdy;
  assign adv1     = !vld_p1 || adv2;
  assign accept   = bus.dv && adv1;
  assign bus.drdy = adv1;
  assign bus.y    = y_p2;
  assign bus.yv   = vld_p2;
  assign bus.ovf  = ovf_q;

  // A clear coinciding with an accepted beat forces that beat onto phase 0.
  assign phase_use = phase && !bus.phclr;

  always_comb begin
    neg_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      unique case (bus.mode)
        2'b00: neg_d[k] = 1'b0;
        2'b01: neg_d[k] = 1'b1;
        2'b10: neg_d[k] = phase_use;
        2'b11: neg_d[k] = (k % 2 == 1);
      endcase
    end
  end

  // ---- S1: capture per-channel negate flag and one's complement ----
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_p1 <= neg_d;
      for (int k = 0; k < CHANNELS; k++)
        dat_p1[k] <= neg_d[k] ? ~bus.din[k*WIDTH +: WIDTH] : bus.din[k*WIDTH +: WIDTH];
    end
  end

  // ---- S2: complete the negate, saturate or wrap ----
  always_comb begin
    ovf_ch = '0;
    y_d    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum_p2[k]              = add_guard(dat_p1[k], neg_p1[k]);
      ovf_ch[k]              = sat_wrap_ovf(sum_p2[k]);
      y_d[k*WIDTH +: WIDTH]  = sat_wrap(sum_p2[k]);
    end
  end

  // Y is reset too so it is never X; it only updates when a real beat moves into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      y_p2   <= '0;
      ovf_q  <= 1'b0;
      phase  <= 1'b0;
    end else begin
      if (adv1)
        vld_p1 <= bus.dv;
      if (adv2)
        vld_p2 <= vld_p1;
      if (adv2 && vld_p1)
        y_p2 <= y_d;

      if (accept)
        phase <= bus.phclr ? 1'b1 : !phase;
      else if (bus.phclr)
        phase <= 1'b0;

      if (adv2 && vld_p1 && (|ovf_ch))
        ovf_q <= 1'b1;
      else if (bus.ovfclr)
        ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tc_negate_pipe.sv
// Scoreboard bench for tc_negate_pipe: a saturating and a wrapping instance run the same
// stimulus; a spec-level model predicts each beat, a monitor pops and compares on handshake.
module tb_tc_negate_pipe;

  localparam int W    = 16;
  localparam int CH   = 2;
  localparam int CW   = W * CH;
  localparam int MAXV = (1 << (W - 1)) - 1;

  typedef struct {
    logic [CW-1:0] ysat;
    logic [CW-1:0] ywrap;
    bit            ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tc_negate_pipe_if #(.WIDTH(W), .CHANNELS(CH)) if0 ();
  tc_negate_pipe_if #(.WIDTH(W), .CHANNELS(CH)) if1 ();

  assign if1.din    = if0.din;
  assign if1.dv     = if0.dv;
  assign if1.mode   = if0.mode;
  assign if1.phclr  = if0.phclr;
  assign if1.yrdy   = if0.yrdy;
  assign if1.ovfclr = if0.ovfclr;

  tc_negate_pipe #(.WIDTH(W), .CHANNELS(CH), .SAT(1'b1)) dut_sat  (.clk(clk), .rst_n(rst_n), .bus(if0));
  tc_negate_pipe #(.WIDTH(W), .CHANNELS(CH), .SAT(1'b0)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(if1));

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   exp_ovf = 1'b0;
  bit   ph = 1'b0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: negate as integer arithmetic, then clamp or wrap anything above the max.
  function automatic logic [W-1:0] ref_ch(input logic [W-1:0] d, input bit n, input bit sat,
                                          output bit ov);
    int v;
    v  = int'($signed(d));
    if (n) v = -v;
    ov = 1'b0;
    if (v > MAXV) begin
      ov = 1'b1;
      v  = sat ? MAXV : v - (1 << W);
    end
    return v[W-1:0];
  endfunction

  task automatic record();
    exp_t e;
    bit   use_ph, n, o1, o2;
    use_ph = if0.phclr ? 1'b0 : ph;
    ph     = if0.phclr ? 1'b1 : !ph;
    e.ov   = 1'b0;
    for (int k = 0; k < CH; k++) begin
      case (if0.mode)
        2'd0:    n = 1'b0;
        2'd1:    n = 1'b1;
        2'd2:    n = use_ph;
        default: n = (k % 2 == 1);
      endcase
      e.ysat[k*W +: W]  = ref_ch(if0.din[k*W +: W], n, 1'b1, o1);
      e.ywrap[k*W +: W] = ref_ch(if0.din[k*W +: W], n, 1'b0, o2);
      e.ov = e.ov | o1;
    end
    sb.push_back(e);
  endtask

  // One clock of stimulus: check ready against pipeline occupancy, record any accept.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = 1'b0;
    chk("drdy", 64'(if0.drdy), 64'(!(sb.size() == 2 && !if0.yrdy)));
    if (if0.dv && if0.drdy) begin
      record();
      acc = 1'b1;
    end else if (if0.phclr) begin
      ph = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] d, input logic [1:0] m, input bit pc);
    bit acc;
    if0.din   = d;
    if0.mode  = m;
    if0.phclr = pc;
    if0.dv    = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step(acc);
    if (!acc) fail_now("send_timeout");
    if0.dv    = 1'b0;
    if0.phclr = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 50 && sb.size() != 0; i++) step(acc);
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n && if0.yv && if0.yrdy) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        e = sb.pop_front();
        if (e.ov) exp_ovf = 1'b1;
        chk("y_sat",  64'(if0.y),  64'(e.ysat));
        chk("y_wrap", 64'(if1.y),  64'(e.ywrap));
        chk("yv_pair", 64'(if1.yv), 64'(1));
        chk("ovf_sat",  64'(if0.ovf), 64'(exp_ovf));
        chk("ovf_wrap", 64'(if1.ovf), 64'(exp_ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    if0.din = '0; if0.dv = 1'b0; if0.mode = 2'd0; if0.phclr = 1'b0;
    if0.yrdy = 1'b1; if0.ovfclr = 1'b0;

    // reset state
    #12;
    chk("rst_yv",  64'(if0.yv),  64'(0));
    chk("rst_y",   64'(if0.y),   64'(0));
    chk("rst_ovf", 64'(if0.ovf), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("drdy_after_rst", 64'(if0.drdy), 64'(1));

    // negate all, latency 2
    send({16'h7FFF, 16'h0001}, 2'b01, 1'b0);
    chk("lat_s1_only", 64'(if0.yv), 64'(0));
    @(posedge clk);
    #1;
    chk("lat_yv", 64'(if0.yv), 64'(1));
    chk("lat_y",  64'(if0.y),  64'({16'h8001, 16'hFFFF}));
    drain();
    chk("ovf_clean", 64'(if0.ovf), 64'(0));

    // most-negative value: saturate vs wrap, then clear
    send({16'h0000, 16'h8000}, 2'b01, 1'b0);
    drain();
    chk("ovf_set_sat",  64'(if0.ovf), 64'(1));
    chk("ovf_set_wrap", 64'(if1.ovf), 64'(1));
    if0.ovfclr = 1'b1;
    step(acc);
    if0.ovfclr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_cleared", 64'(if0.ovf), 64'(0));

    // alternate sign after an idle phase clear
    if0.phclr = 1'b1;
    step(acc);
    if0.phclr = 1'b0;
    for (int i = 0; i < 4; i++) send({16'h0100, 16'h0100}, 2'b10, 1'b0);
    drain();

    // odd-channel negate
    send({16'h1234, 16'h1234}, 2'b11, 1'b0);
    drain();

    // random stream with random back-pressure
    for (int c = 0; c < 400; c++) begin
      logic [CW-1:0] d;
      for (int k = 0; k < CH; k++)
        d[k*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
      if0.din   = d;
      if0.dv    = 1'($urandom_range(0, 1));
      if0.mode  = 2'($urandom_range(0, 3));
      if0.phclr = ($urandom_range(0, 15) == 0);
      if0.yrdy  = 1'($urandom_range(0, 1));
      step(acc);
    end
    if0.dv = 1'b0; if0.phclr = 1'b0; if0.yrdy = 1'b1;
    drain();

    // reset with both stages full
    if0.yrdy = 1'b0;
    if0.din  = {16'h8000, 16'h8000};
    if0.mode = 2'b01;
    if0.dv   = 1'b1;
    for (int i = 0; i < 10 && if0.drdy; i++) step(acc);
    chk("full_stall", 64'(if0.drdy), 64'(0));
    chk("ovf_before_rst", 64'(if0.ovf), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_yv",  64'(if0.yv),  64'(0));
    chk("midrst_y",   64'(if0.y),   64'(0));
    chk("midrst_ovf", 64'(if0.ovf), 64'(0));
    chk("midrst_ovf_wrap", 64'(if1.ovf), 64'(0));
    sb.delete();
    exp_ovf = 1'b0;
    ph = 1'b0;
    if0.dv = 1'b0;
    if0.yrdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send({16'h0100, 16'h0100}, 2'b10, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
